// File: rtl/dffsnq_preseq_pkg.sv
// Shared types and constants for the SETN preset sequencer.
package dffsnq_preseq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RECOVER = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int PW_DEF  = 3;
    localparam int REC_DEF = 2;

    // Wide enough to hold the longest phase length without wrapping.
    function automatic int tmr_w(input int pw, input int rec);
        return $clog2(((pw > rec) ? pw : rec) + 1);
    endfunction

endpackage

// File: rtl/dffsnq_preseq_timer.sv
// Loadable down-counter with a zero flag; it parks at zero rather than wrapping.
module dffsnq_preseq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dffsnq_preset_sequencer.sv
// Presets NGRP set-type flop groups one at a time: SETN pulse, then a recovery window with CKEN low.
// Define DFFSNQ_PRESEQ_MASK_EN to add the MASK port for skipping groups.
module dffsnq_preset_sequencer
    import dffsnq_preseq_pkg::*;
#(
    parameter int NGRP = 4,
    parameter int PW   = PW_DEF,
    parameter int REC  = REC_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ,
`ifdef DFFSNQ_PRESEQ_MASK_EN
    input  logic [NGRP-1:0] MASK,
`endif
    output logic            ACK,
    output logic            BUSY,
    output logic [NGRP-1:0] SETN,
    output logic [NGRP-1:0] CKEN
);

    localparam int TW = tmr_w(PW, REC);
    localparam int GW = (NGRP > 1) ? $clog2(NGRP) : 1;

    state_t          state, state_nx;
    logic [GW-1:0]   grp, grp_nx;
    logic [NGRP-1:0] msk, msk_nx, mask_in;
    logic            tmr_load, tmr_zero;
    logic [TW-1:0]   tmr_val;
    logic [GW:0]     srch;
    logic [NGRP-1:0] setn_nx, cken_nx;
    logic            ack_nx, busy_nx;

`ifdef DFFSNQ_PRESEQ_MASK_EN
    assign mask_in = MASK;
`else
    assign mask_in = '0;
`endif

    // Lowest unmasked group at or above lo; MSB flags whether one exists.
    function automatic logic [GW:0] first_free(input logic [NGRP-1:0] m, input int lo);
        logic [GW:0] r;
        r = '0;
        for (int i = NGRP - 1; i >= 0; i--)
            if (i >= lo && !m[i])
                r = {1'b1, GW'(i)};
        return r;
    endfunction

    dffsnq_preseq_timer #(.W(TW)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nx = state;
        grp_nx   = grp;
        msk_nx   = msk;
        srch     = '0;
        unique case (state)
            IDLE: if (REQ) begin
                msk_nx = mask_in;
                srch   = first_free(mask_in, 0);
                if (srch[GW]) begin
                    state_nx = ASSERT;
                    grp_nx   = srch[GW-1:0];
                end else begin
                    state_nx = DONE;
                end
            end
            ASSERT: if (tmr_zero)
                state_nx = RECOVER;
            RECOVER: if (tmr_zero) begin
                srch = first_free(msk, int'(grp) + 1);
                if (srch[GW]) begin
                    state_nx = ASSERT;
                    grp_nx   = srch[GW-1:0];
                end else begin
                    state_nx = DONE;
                end
            end
            DONE: if (!REQ)
                state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Every transition (including RECOVER -> ASSERT) is a state change, so reload on change.
    always_comb begin
        tmr_load = (state_nx != state);
        tmr_val  = '0;
        if (state_nx == ASSERT)
            tmr_val = TW'(PW - 1);
        else if (state_nx == RECOVER)
            tmr_val = TW'(REC - 1);
    end

    // Outputs are decoded from the next state so the registered pins line up with the FSM.
    always_comb begin
        setn_nx = '1;
        cken_nx = '1;
        ack_nx  = (state_nx == DONE);
        busy_nx = (state_nx == ASSERT) || (state_nx == RECOVER);
        if (state_nx == ASSERT) begin
            setn_nx[grp_nx] = 1'b0;
            cken_nx[grp_nx] = 1'b0;
        end else if (state_nx == RECOVER) begin
            cken_nx[grp_nx] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            grp   <= '0;
            msk   <= '0;
            SETN  <= '1;
            CKEN  <= '1;
            ACK   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nx;
            grp   <= grp_nx;
            msk   <= msk_nx;
            SETN  <= setn_nx;
            CKEN  <= cken_nx;
            ACK   <= ack_nx;
            BUSY  <= busy_nx;
        end
    end

endmodule

// File: tb/tb_dffsnq_preset_sequencer.sv
// Directed bench for dffsnq_preset_sequencer (NGRP=4, PW=3, REC=2); edge labels restart per scenario.
module tb_dffsnq_preset_sequencer;

    localparam int NG  = 4;
    localparam int PW  = 3;
    localparam int REC = 2;
    localparam int T   = PW + REC;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ;
    logic [NG-1:0] MASK;
    logic          ACK, BUSY;
    logic [NG-1:0] SETN, CKEN;

    int checks = 0;
    int errors = 0;
    int e;

    dffsnq_preset_sequencer #(.NGRP(NG), .PW(PW), .REC(REC)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
`ifdef DFFSNQ_PRESEQ_MASK_EN
        .MASK (MASK),
`endif
        .ACK  (ACK),
        .BUSY (BUSY),
        .SETN (SETN),
        .CKEN (CKEN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, e, got, exp);
        end
    endtask

    // Leaves the bench at the negedge before edge e: outputs show their value at edge e.
    task automatic step();
        @(posedge CLK);
        e++;
        @(negedge CLK);
    endtask

    task automatic check_outs(input logic [NG-1:0] es, input logic [NG-1:0] ec,
                              input logic ea, input logic eb);
        check("setn", SETN, es);
        check("cken", CKEN, ec);
        check("ack",  ACK,  ea);
        check("busy", BUSY, eb);
    endtask

    // REQ sampled high at edge k and first sampled low at edge d; m = skipped groups.
    task automatic model(input int ee, input int k, input int d, input logic [NG-1:0] m,
                         output logic [NG-1:0] es, output logic [NG-1:0] ec,
                         output logic ea, output logic eb);
        int n, rel, g, cnt, ack0, ackend;
        es = '1; ec = '1; ea = 1'b0; eb = 1'b0;
        n = 0;
        for (int i = 0; i < NG; i++) if (!m[i]) n++;
        ack0   = k + 1 + n * T;
        ackend = (d > ack0) ? d : ack0;
        if (ee > k && ee <= ackend) begin
            rel = ee - k - 1;
            if (rel < n * T) begin
                g = 0; cnt = 0;
                for (int i = 0; i < NG; i++)
                    if (!m[i]) begin
                        if (cnt == rel / T) g = i;
                        cnt++;
                    end
                ec[g] = 1'b0;
                if (rel % T < PW) es[g] = 1'b0;
                eb = 1'b1;
            end else begin
                ea = 1'b1;
            end
        end
    endtask

    // Optional RST pulse at rst_e; afterwards a second request window [k2, d2) applies.
    task automatic run_seq(input int k, input int d, input int rst_e, input int k2, input int d2,
                           input logic [NG-1:0] m, input int last, input bit spots);
        logic [NG-1:0] es, ec;
        logic          ea, eb;
        e = 0;
        while (e <= last) begin
            RST  = (e == rst_e);
            REQ  = (e >= k && e < d) || (e >= k2 && e < d2);
            MASK = m;
            if (rst_e >= 0 && e > rst_e) model(e, k2, d2, m, es, ec, ea, eb);
            else                         model(e, k,  d,  m, es, ec, ea, eb);
            check_outs(es, ec, ea, eb);
            if (spots) begin
                case (e)
                    13: check("spot_setn13", SETN, 4'b1110);
                    15: check("spot_cken15", CKEN, 4'b1110);
                    16: check("spot_setn16", SETN, 4'b1101);
                    26: check("spot_setn26", SETN, 4'b0111);
                    30: check("spot_ack30",  ACK,  1'b0);
                    31: check("spot_ack31",  ACK,  1'b1);
                    41: check("spot_ack41",  ACK,  1'b1);
                    42: check("spot_ack42",  ACK,  1'b0);
                    default: ;
                endcase
            end
            step();
        end
        RST = 1'b0;
        REQ = 1'b0;
    endtask

    initial begin
        e    = 0;
        RST  = 1'b1;
        REQ  = 1'b1;
        MASK = '0;
        step();
        check_outs(4'b1111, 4'b1111, 1'b0, 1'b0);
        step();
        check_outs(4'b1111, 4'b1111, 1'b0, 1'b0);
        RST = 1'b0;
        REQ = 1'b0;
        step();
        check_outs(4'b1111, 4'b1111, 1'b0, 1'b0);
        step();
        check_outs(4'b1111, 4'b1111, 1'b0, 1'b0);

        // REQ held through edge 40: ACK 31..41, then idle with no restart.
        run_seq(10, 41, -1, -1, -1, 4'b0000, 46, 1'b1);
        // REQ dropped at edge 14: sequence still completes, ACK only at edge 31.
        run_seq(10, 14, -1, -1, -1, 4'b0000, 36, 1'b0);
        // RST at edge 18 while group 1 is asserted; new request at edge 22.
        run_seq(10, 14, 18, 22, 23, 4'b0000, 47, 1'b0);
`ifdef DFFSNQ_PRESEQ_MASK_EN
        // Groups 0 and 2 skipped: ACK at edge 21.
        run_seq(10, 11, -1, -1, -1, 4'b0101, 25, 1'b0);
        // Everything skipped: ACK at edge 11 with no SETN activity.
        run_seq(10, 11, -1, -1, -1, 4'b1111, 14, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
